// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: producer-to-writeback result handshake (valid/ready with destination and data)
interface regfile_writeback_if #(
  parameter int ADDRSIZE = 5,
  parameter int WORDSIZE = 64
);
  logic                valid;
  logic                ready;
  logic [ADDRSIZE-1:0] rd;
  logic [WORDSIZE-1:0] data;
  modport master(output valid, rd, data, input ready);
  modport slave(input valid, rd, data, output ready);
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: two-producer writeback arbiter with per-register busy scoreboard
module regfile_writeback #(
  parameter int ADDRSIZE = 5,
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst,
  regfile_writeback_if.slave  alu,
  regfile_writeback_if.slave  ld,
  input  logic                iss_valid,
  input  logic [ADDRSIZE-1:0] iss_rd,
  input  logic [ADDRSIZE-1:0] q_rs1,
  input  logic [ADDRSIZE-1:0] q_rs2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                regwr,
  output logic [ADDRSIZE-1:0] rd,
  output logic [WORDSIZE-1:0] rddata
);
  localparam int NREG = 1 << ADDRSIZE;
  typedef enum logic {LAST_ALU, LAST_LD} last_t;
  logic                a_v_q, a_v_d, l_v_q, l_v_d, regwr_q, regwr_d;
  logic [ADDRSIZE-1:0] a_rd_q, a_rd_d, l_rd_q, l_rd_d, rd_q, rd_d, g_rd;
  logic [WORDSIZE-1:0] a_data_q, a_data_d, l_data_q, l_data_d, rddata_q, rddata_d, g_data;
  logic [NREG-1:0]     busy_q, busy_d;
  last_t               last_q, last_d;
  logic                gnt_a, gnt_l, a_rdy, l_rdy, a_xfer, l_xfer;
  assign alu.ready = a_rdy;
  assign ld.ready  = l_rdy;
  assign rs1_busy  = busy_q[q_rs1];
  assign rs2_busy  = busy_q[q_rs2];
  assign regwr     = regwr_q;
  assign rd        = rd_q;
  assign rddata    = rddata_q;
  always_comb begin
    gnt_a    = a_v_q && (!l_v_q || last_q == LAST_LD);
    gnt_l    = l_v_q && (!a_v_q || last_q == LAST_ALU);
    a_rdy    = !a_v_q || gnt_a;
    l_rdy    = !l_v_q || gnt_l;
    a_xfer   = alu.valid && a_rdy;
    l_xfer   = ld.valid && l_rdy;
    g_rd     = gnt_a ? a_rd_q : l_rd_q;
    g_data   = gnt_a ? a_data_q : l_data_q;
    a_v_d    = a_xfer || (a_v_q && !gnt_a);
    a_rd_d   = a_xfer ? alu.rd : a_rd_q;
    a_data_d = a_xfer ? alu.data : a_data_q;
    l_v_d    = l_xfer || (l_v_q && !gnt_l);
    l_rd_d   = l_xfer ? ld.rd : l_rd_q;
    l_data_d = l_xfer ? ld.data : l_data_q;
    // x0 grants drain the entry but never raise the write strobe
    regwr_d  = (gnt_a || gnt_l) && g_rd != '0;
    rd_d     = (gnt_a || gnt_l) ? g_rd : rd_q;
    rddata_d = (gnt_a || gnt_l) ? g_data : rddata_q;
    last_d   = (a_v_q && l_v_q) ? (gnt_a ? LAST_ALU : LAST_LD) : last_q;
    busy_d   = busy_q;
    if (regwr_d) busy_d[g_rd] = 1'b0;
    if (iss_valid) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_v_q    <= 1'b0;
      a_rd_q   <= '0;
      a_data_q <= '0;
      l_v_q    <= 1'b0;
      l_rd_q   <= '0;
      l_data_q <= '0;
      regwr_q  <= 1'b0;
      rd_q     <= '0;
      rddata_q <= '0;
      busy_q   <= '0;
      last_q   <= LAST_ALU;
    end else begin
      a_v_q    <= a_v_d;
      a_rd_q   <= a_rd_d;
      a_data_q <= a_data_d;
      l_v_q    <= l_v_d;
      l_rd_q   <= l_rd_d;
      l_data_q <= l_data_d;
      regwr_q  <= regwr_d;
      rd_q     <= rd_d;
      rddata_q <= rddata_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: randomized traffic against a port-level reference model, plus directed literal cases
module tb_regfile_writeback;
  localparam int A = 5;
  localparam int W = 64;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  regfile_writeback_if #(.ADDRSIZE(A), .WORDSIZE(W)) aif ();
  regfile_writeback_if #(.ADDRSIZE(A), .WORDSIZE(W)) lif ();
  logic         iss_valid = 0;
  logic [A-1:0] iss_rd = 0, q_rs1 = 0, q_rs2 = 0;
  logic         rs1_busy, rs2_busy, regwr;
  logic [A-1:0] rd;
  logic [W-1:0] rddata;
  regfile_writeback #(.ADDRSIZE(A), .WORDSIZE(W)) dut (
    .clk(clk), .rst(rst), .alu(aif.slave), .ld(lif.slave),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .q_rs1(q_rs1), .q_rs2(q_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .regwr(regwr), .rd(rd), .rddata(rddata)
  );
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: port 0 = ALU, port 1 = load
  bit           mv[2];
  logic [A-1:0] mrd[2];
  logic [W-1:0] mdata[2];
  int           mlast;
  bit           mx[2];
  bit           e_regwr;
  logic [A-1:0] e_rd;
  logic [W-1:0] e_data;
  bit           mbusy[32];
  int           g;
  bit           iv[2];
  logic [A-1:0] ir[2];
  logic [W-1:0] id[2];
  function automatic int pick();
    if (mv[0] && mv[1]) return (mlast == 0) ? 1 : 0;
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction
  function automatic bit mready(int p);
    return !mv[p] || pick() == p;
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin mv[p] = 0; mx[p] = 0; end
      for (int i = 0; i < 32; i++) mbusy[i] = 0;
      mlast = 0; e_regwr = 0; e_rd = 0; e_data = 0;
    end else begin
      g = pick();
      iv[0] = aif.valid; ir[0] = aif.rd; id[0] = aif.data;
      iv[1] = lif.valid; ir[1] = lif.rd; id[1] = lif.data;
      for (int p = 0; p < 2; p++) mx[p] = iv[p] && mready(p);
      e_regwr = 0;
      if (g >= 0) begin
        e_regwr = mrd[g] != 0;
        e_rd = mrd[g];
        e_data = mdata[g];
        if (mrd[g] != 0) mbusy[mrd[g]] = 0;
      end
      if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1;
      if (mv[0] && mv[1]) mlast = g;
      for (int p = 0; p < 2; p++)
        if (mx[p]) begin mv[p] = 1; mrd[p] = ir[p]; mdata[p] = id[p]; end
        else if (g == p) mv[p] = 0;
    end
  end
  logic [A-1:0] wq_rd[$];
  logic [W-1:0] wq_d[$];
  bit rec = 0;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      check("regwr", regwr, e_regwr);
      if (e_regwr) begin
        check("rd", rd, e_rd);
        check("rddata", rddata, e_data);
      end
      check("alu_ready", aif.ready, mready(0));
      check("ld_ready", lif.ready, mready(1));
      check("rs1_busy", rs1_busy, mbusy[q_rs1]);
      check("rs2_busy", rs2_busy, mbusy[q_rs2]);
      if (rec && regwr) begin wq_rd.push_back(rd); wq_d.push_back(rddata); end
    end
  end
  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask
  int ia, il;
  initial begin
    aif.valid = 0; aif.rd = 0; aif.data = 0;
    lif.valid = 0; lif.rd = 0; lif.data = 0;
    // valid during reset must not be captured
    @(negedge clk);
    aif.valid = 1; aif.rd = 5; aif.data = 1;
    repeat (3) @(negedge clk);
    check("rst_regwr", regwr, 0);
    check("rst_rd", rd, 0);
    check("rst_rddata", rddata, 0);
    check("rst_alu_ready", aif.ready, 1);
    check("rst_ld_ready", lif.ready, 1);
    aif.valid = 0;
    rst = 1;
    // single write
    @(negedge clk);
    aif.valid = 1; aif.rd = 5; aif.data = 64'hDEAD;
    @(negedge clk);
    aif.valid = 0;
    after_edge();
    check("single_regwr", regwr, 1);
    check("single_rd", rd, 5);
    check("single_data", rddata, 64'hDEAD);
    after_edge();
    check("single_regwr_off", regwr, 0);
    // conflict right after reset, then continuous alternating traffic
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    ia = 0; il = 0;
    aif.valid = 1; aif.rd = 3; aif.data = 64'hA000;
    lif.valid = 1; lif.rd = 4; lif.data = 64'hB000;
    rec = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mx[0]) ia++;
      if (mx[1]) il++;
      aif.valid = ia < 10; aif.data = 64'hA000 + 64'(ia);
      lif.valid = il < 10; lif.data = 64'hB000 + 64'(il);
    end
    rec = 0;
    check("bp_count", 64'(wq_rd.size()), 20);
    for (int k = 0; k < 20; k++) begin
      check("bp_rd", k < wq_rd.size() ? wq_rd[k] : 'x, (k % 2 == 0) ? 4 : 3);
      check("bp_data", k < wq_d.size() ? wq_d[k] : 'x,
            ((k % 2 == 0) ? 64'hB000 : 64'hA000) + 64'(k / 2));
    end
    // x0 drop
    @(negedge clk);
    lif.valid = 1; lif.rd = 0; lif.data = 64'hFF;
    iss_valid = 1; iss_rd = 0; q_rs1 = 0;
    @(negedge clk);
    lif.valid = 0; iss_valid = 0;
    after_edge();
    check("x0_regwr", regwr, 0);
    check("x0_ld_ready", lif.ready, 1);
    check("x0_busy", rs1_busy, 0);
    // scoreboard set/clear
    @(negedge clk);
    iss_valid = 1; iss_rd = 7; q_rs1 = 7;
    @(negedge clk);
    iss_valid = 0;
    check("sb_set", rs1_busy, 1);
    aif.valid = 1; aif.rd = 7; aif.data = 64'h77;
    @(negedge clk);
    aif.valid = 0;
    check("sb_hold", rs1_busy, 1);
    @(negedge clk);
    check("sb_clear", rs1_busy, 0);
    check("sb_regwr", regwr, 1);
    check("sb_rd", rd, 7);
    // same-edge set and clear: set wins
    aif.valid = 1; aif.rd = 7; aif.data = 64'h78; iss_valid = 1; iss_rd = 7;
    @(negedge clk);
    aif.valid = 0;
    @(negedge clk);
    iss_valid = 0;
    check("sb_setwins", rs1_busy, 1);
    check("sb_setwins_rd", rd, 7);
    check("sb_setwins_data", rddata, 64'h78);
    // reset mid-flight
    @(negedge clk);
    aif.valid = 1; aif.rd = 10; aif.data = 1;
    lif.valid = 1; lif.rd = 11; lif.data = 2;
    iss_valid = 1; iss_rd = 9; q_rs2 = 9;
    @(negedge clk);
    iss_valid = 0;
    check("mid_busy9", rs2_busy, 1);
    #2 rst = 0;
    #1;
    check("mid_regwr", regwr, 0);
    check("mid_busy9_clr", rs2_busy, 0);
    check("mid_busy7_clr", rs1_busy, 0);
    check("mid_alu_ready", aif.ready, 1);
    check("mid_ld_ready", lif.ready, 1);
    aif.valid = 0; lif.valid = 0;
    @(negedge clk);
    rst = 1;
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) begin
        rst = 0;
        @(negedge clk);
        rst = 1;
      end
      if (!aif.valid || mx[0]) begin
        aif.valid = $urandom_range(0, 3) != 0;
        aif.rd = A'($urandom_range(0, 31));
        aif.data = {$urandom(), $urandom()};
      end
      if (!lif.valid || mx[1]) begin
        lif.valid = $urandom_range(0, 3) != 0;
        lif.rd = A'($urandom_range(0, 31));
        lif.data = {$urandom(), $urandom()};
      end
      iss_valid = $urandom_range(0, 2) == 0;
      iss_rd = A'($urandom_range(0, 31));
      q_rs1 = A'($urandom_range(0, 31));
      q_rs2 = A'($urandom_range(0, 31));
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
